// File: rtl/grid_input_loader_pkg.sv
// Shared RCA grid configuration, the operand bundle layout and the loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rca_config;
    localparam int XLEN           = 32;
    localparam int GRID_NUM_ROWS  = 4;
    localparam int NUM_READ_PORTS = 2;
    localparam int ROW_SEL_W      = $clog2(GRID_NUM_ROWS);
    localparam int BUNDLE_ID_W    = 4;

    typedef struct packed {
        logic [NUM_READ_PORTS-1:0][XLEN-1:0]      rs_data;
        logic [NUM_READ_PORTS-1:0][ROW_SEL_W-1:0] sels;
        logic [NUM_READ_PORTS-1:0]                port_en;
        logic [BUNDLE_ID_W-1:0]                   id;
    } grid_load_bundle_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_WAIT_WB = 2'd2
    } loader_state_t;
endpackage

// File: rtl/grid_input_loader_fifo.sv
// Circular bundle queue with occupancy counter; head is visible combinationally.
// Latency: a push is poppable the cycle after it is written.
// Backpressure: a full queue refuses a push even when a pop happens in the same cycle.
module rca_bundle_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  T                         push_dat,
    input  logic                     pop,
    output T                         pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/grid_input_loader.sv
// Queues RCA operand bundles and drives one at a time onto the grid IO-unit input rows.
// Latency: accept at N -> row valids at N+2 from idle; back-to-back load one cycle after writeback commit.
// Backpressure: issue_ready drops when the queue holds FIFO_DEPTH bundles.
module grid_input_loader
    import rca_config::*;
#(
    parameter int GRID_NUM_ROWS  = rca_config::GRID_NUM_ROWS,
    parameter int NUM_READ_PORTS = rca_config::NUM_READ_PORTS,
    parameter int FIFO_DEPTH     = 2,
    parameter int ID_W           = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  flush,
    input  logic                                                  issue_valid,
    output logic                                                  issue_ready,
    input  logic [NUM_READ_PORTS-1:0][rca_config::XLEN-1:0]       issue_rs_data,
    input  logic [NUM_READ_PORTS-1:0][$clog2(GRID_NUM_ROWS)-1:0]  issue_io_unit_sels,
    input  logic [NUM_READ_PORTS-1:0]                             issue_port_en,
    input  logic [ID_W-1:0]                                       issue_id,
    output logic [GRID_NUM_ROWS-1:0][rca_config::XLEN-1:0]        io_unit_input_data,
    output logic [GRID_NUM_ROWS-1:0]                              io_unit_input_data_valid,
    input  logic                                                  grid_ready,
    input  logic                                                  wb_committing,
    output logic [ID_W-1:0]                                       inflight_id,
    output logic                                                  busy,
    output logic                                                  sel_conflict
);
    localparam int SEL_W = $clog2(GRID_NUM_ROWS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DW    = rca_config::XLEN;

    typedef struct packed {
        logic [NUM_READ_PORTS-1:0][DW-1:0]    rs_data;
        logic [NUM_READ_PORTS-1:0][SEL_W-1:0] sels;
        logic [NUM_READ_PORTS-1:0]            port_en;
        logic [ID_W-1:0]                      id;
    } bundle_t;

    loader_state_t                    state_q, state_d;
    bundle_t                          push_bundle;
    bundle_t                          head;
    logic [CNT_W-1:0]                 fifo_count;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic [GRID_NUM_ROWS-1:0]         dec_valid;
    logic [GRID_NUM_ROWS-1:0][DW-1:0] dec_data;
    logic                             dec_conflict;

    assign issue_ready = !rst && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push   = issue_valid && issue_ready && !flush;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;

    assign push_bundle.rs_data = issue_rs_data;
    assign push_bundle.sels    = issue_io_unit_sels;
    assign push_bundle.port_en = issue_port_en;
    assign push_bundle.id      = issue_id;

    rca_bundle_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (bundle_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .push     (fifo_push),
        .push_dat (push_bundle),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    // Ports are scanned high to low so the lowest-index enabled port wins a shared row.
    always_comb begin
        dec_valid    = '0;
        dec_data     = '0;
        dec_conflict = 1'b0;
        for (int r = 0; r < GRID_NUM_ROWS; r++) begin
            for (int p = NUM_READ_PORTS - 1; p >= 0; p--) begin
                if (head.port_en[p] && (head.sels[p] == SEL_W'(r))) begin
                    if (dec_valid[r]) dec_conflict = 1'b1;
                    dec_valid[r] = 1'b1;
                    dec_data[r]  = head.rs_data[p];
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (grid_ready) state_d = ST_WAIT_WB;
            end
            ST_WAIT_WB: begin
                if (wb_committing) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_DRIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q                  <= ST_IDLE;
            io_unit_input_data_valid <= '0;
            io_unit_input_data       <= '0;
            inflight_id              <= '0;
            sel_conflict             <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_conflict <= fifo_pop && dec_conflict;
            if (fifo_pop) begin
                io_unit_input_data_valid <= dec_valid;
                io_unit_input_data       <= dec_data;
                inflight_id              <= head.id;
            end else if (state_q == ST_DRIVE && grid_ready) begin
                io_unit_input_data_valid <= '0;
            end
        end
    end
endmodule

// File: doc/grid_input_loader.md
# grid_input_loader

Issue-side counterpart to the grid writeback selector. Accepts RCA operand bundles (source register values plus per-port IO-unit row selects), queues them in a small FIFO, and drives the register operands onto the selected IO-unit input rows of the grid. It keeps exactly one bundle in flight and releases the next bundle only after the grid signals consumption (`grid_ready`) and writeback commit (`wb_committing`).

## Interface
- `GRID_NUM_ROWS`, default `rca_config::GRID_NUM_ROWS`: number of IO-unit rows.
- `NUM_READ_PORTS`, default `rca_config::NUM_READ_PORTS`: operand ports per bundle.
- `FIFO_DEPTH`, default 2: queued bundles, must be a power of two ≥2.
- `ID_W`, default 4: bundle tag width.
- `clk` in 1: clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: drops queued and in-flight bundles.
- `issue_valid` in 1: bundle offered.
- `issue_ready` out 1: bundle accepted when `issue_valid && issue_ready`.
- `issue_rs_data` in `[XLEN-1:0] x NUM_READ_PORTS`: operand values.
- `issue_io_unit_sels` in `[$clog2(GRID_NUM_ROWS)-1:0] x NUM_READ_PORTS`: target row per port.
- `issue_port_en` in `NUM_READ_PORTS`: port p used.
- `issue_id` in `ID_W`: bundle tag.
- `io_unit_input_data` out `[XLEN-1:0] x GRID_NUM_ROWS`: operand per row.
- `io_unit_input_data_valid` out `GRID_NUM_ROWS`: row carries a valid operand.
- `grid_ready` in 1: grid latches the presented operands this cycle.
- `wb_committing` in 1: in-flight bundle's writeback commits this cycle.
- `inflight_id` out `ID_W`: tag of the bundle in DRIVE/WAIT_WB.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `sel_conflict` out 1: one-cycle pulse, loaded bundle had two enabled ports on one row.

## Operation
- FIFO: circular, `FIFO_DEPTH` entries, read/write pointers wrap modulo depth, occupancy counter `0..FIFO_DEPTH`. `issue_ready = !rst && count < FIFO_DEPTH`, depends on count only. A full FIFO refuses a push even in a cycle where a pop occurs.
- FSM states IDLE, DRIVE, WAIT_WB:
  - IDLE with FIFO non-empty: pop head, load output registers, go to DRIVE.
  - DRIVE with `grid_ready`: clear all row valids, go to WAIT_WB. Otherwise hold the outputs stable.
  - WAIT_WB with `wb_committing`: if FIFO non-empty, pop and load, stay in DRIVE-path (go to DRIVE). Otherwise go to IDLE.
  - `wb_committing` outside WAIT_WB is ignored. `grid_ready` outside DRIVE is ignored.
- Load decode: for each row r, valid[r] = OR over p of (`port_en[p] && sel[p]==r`).
  - data[r] = `rs_data` of the lowest-index enabled port selecting r, else 0.
  - If more than one enabled port selects r, pulse `sel_conflict` in the cycle after the load.
- A bundle with all ports disabled still passes through DRIVE (no valids asserted) and waits for `grid_ready`.
- `flush` (or `rst`): next cycle state IDLE, count 0, pointers 0, all valids 0, data 0, `inflight_id` 0, `sel_conflict` 0. A push coincident with `flush` is discarded. `rst` has priority over `flush`.

## Timing
- Reset values: all valids 0, data 0, `inflight_id` 0, `busy` 0, `sel_conflict` 0, `issue_ready` 0 during reset and 1 from the first cycle after.
- Latency: bundle accepted at cycle N into an empty FIFO with state IDLE → count 1 at N+1 → row valids visible at N+2.
- Back-to-back: `wb_committing` at cycle M with FIFO non-empty → next bundle's valids visible at M+1.
- All outputs are registered except `issue_ready` and `busy`, which are combinational from registered state.

## Structure
- Package `rca_config` holds `GRID_NUM_ROWS`, `NUM_READ_PORTS` and a `grid_load_bundle_t` typedef (`rs_data`, `sels`, `port_en`, `id`). Shared by the issue stage and this block.
- One sub-module, `rca_bundle_fifo`, parameterised on depth and payload type, implements the FIFO. This block holds the FSM and row decode.

## Test plan
- Single bundle, rows=4, ports=2: `rs_data={0xA,0xB}`, sels={2,0}, en=11, issued at cycle 0 → at cycle 2 valid=4'b0101, row2=0xA, row0=0xB; `grid_ready` at 3 → valids 0 at 4; `wb_committing` at 6 → IDLE at 7, `busy`=0.
- Conflict: sels={1,1}, en=11, data {0x5,0x9} → row1=0x5, valid=4'b0010, `sel_conflict` high exactly one cycle.
- FIFO full: issue 3 bundles while the first waits in DRIVE (depth 2) → bundles 2–3 accepted, `issue_ready` low afterwards until the next pop; tags appear on `inflight_id` in order 1, 2, 3.
- Back-to-back: two bundles queued, `wb_committing` at cycle M → second bundle's valids at M+1; `wb_committing` pulsed during DRIVE is ignored (state unchanged).
- Flush mid-operation: in WAIT_WB with one queued bundle, assert `flush` together with `issue_valid` → next cycle count=0, state IDLE, valids 0, pushed bundle dropped.
- Reset mid-DRIVE: `rst` for one cycle → all outputs at reset values the next cycle; `issue_ready` low during `rst`.
